// File: rtl/led_chase_sequencer_if.sv
// Handshake bundle between the switch front-end and the LED chase sequencer.
// Defining SEQ_PAUSE_EN adds the pause input.
interface led_chase_sequencer_if #(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 24
);
    logic                start;
    logic                stop;
    logic                mode;
    logic                dir;
    logic [CNT_W-1:0]    len;
`ifdef SEQ_PAUSE_EN
    logic                pause;
`endif
    logic [N_STAGES-1:0] stage_out;
    logic                step_one;
    logic                done;
    logic                busy;

`ifdef SEQ_PAUSE_EN
    modport master (
        output start, stop, mode, dir, len, pause,
        input  stage_out, step_one, done, busy
    );
    modport slave (
        input  start, stop, mode, dir, len, pause,
        output stage_out, step_one, done, busy
    );
`else
    modport master (
        output start, stop, mode, dir, len,
        input  stage_out, step_one, done, busy
    );
    modport slave (
        input  start, stop, mode, dir, len,
        output stage_out, step_one, done, busy
    );
`endif
endinterface

// File: rtl/led_chase_sequencer.sv
// Central LED chase sequencer: one stage index, one step-length down-counter, IDLE/RUN FSM.
// Optional SEQ_PAUSE_EN adds a pause input that freezes the running sequence.
module led_chase_sequencer #(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 24
) (
    input  logic                   clk,
    input  logic                   r_n,
    led_chase_sequencer_if.slave   bus
);

    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [IDX_W-1:0]    IDX_ONE  = 1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_STAGES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = 1;
    localparam logic [N_STAGES-1:0] STAGE_ONE = 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [N_STAGES-1:0] stage_out_q, stage_out_next;
    logic                step_one_q, step_one_next;
    logic                done_q, done_next;
    logic                busy_q, busy_next;

    logic                load_first;
    logic                advance;
    logic                finish;
    logic                pause_active;
    logic [CNT_W-1:0]    len_eff;
    logic [IDX_W-1:0]    first_idx;
    logic [IDX_W-1:0]    last_idx;

`ifdef SEQ_PAUSE_EN
    assign pause_active = bus.pause;
`else
    assign pause_active = 1'b0;
`endif

    // A zero length still has to show each stage for one cycle.
    assign len_eff   = (bus.len == '0) ? CNT_ONE : bus.len;
    assign first_idx = bus.dir ? IDX_LAST : '0;
    assign last_idx  = bus.dir ? '0 : IDX_LAST;

    always_ff @(posedge clk) begin
        if (!r_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            stage_out_q <= '0;
            step_one_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            cnt         <= cnt_next;
            stage_out_q <= stage_out_next;
            step_one_q  <= step_one_next;
            done_q      <= done_next;
            busy_q      <= busy_next;
        end
    end

    // Priority in RUN: stop, retrigger, pause, count down, stage end.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_next = RUN;
                    idx_next   = first_idx;
                    cnt_next   = len_eff;
                    load_first = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end else if (bus.start) begin
                    idx_next   = first_idx;
                    cnt_next   = len_eff;
                    load_first = 1'b1;
                end else if (pause_active) begin
                    idx_next   = idx;
                    cnt_next   = cnt;
                end else if (cnt > CNT_ONE) begin
                    cnt_next   = cnt - CNT_ONE;
                end else if (bus.mode && (idx == last_idx)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                    finish     = 1'b1;
                end else begin
                    if (bus.dir)
                        idx_next = (idx == '0) ? IDX_LAST : idx - IDX_ONE;
                    else
                        idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
                    cnt_next   = len_eff;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_next      = (state_next == RUN);
        stage_out_next = busy_next ? (STAGE_ONE << idx_next) : '0;
        step_one_next  = load_first | advance;
        done_next      = finish;
    end

    assign bus.stage_out = stage_out_q;
    assign bus.step_one  = step_one_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_led_chase_sequencer.sv
// Directed self-checking bench for led_chase_sequencer (N_STAGES=4).
// Inputs change 1 time unit after each rising edge; "@n" is the value held after edge n-1.
module tb_led_chase_sequencer;

    localparam int N_STAGES = 4;
    localparam int CNT_W    = 24;

    logic clk;
    logic r_n;
    int   testsRun;
    int   testsFailed;

    led_chase_sequencer_if #(.N_STAGES(N_STAGES), .CNT_W(CNT_W)) bus ();

    led_chase_sequencer #(.N_STAGES(N_STAGES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .r_n (r_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a broken build can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic mode,
                                 input logic dir, input logic [CNT_W-1:0] len);
        bus.start = start;
        bus.stop  = stop;
        bus.mode  = mode;
        bus.dir   = dir;
        bus.len   = len;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] oneHot(input int i);
        logic [31:0] v;
        v = 32'd1 << i;
        return v;
    endfunction

    task automatic checkAll(input string tag, input logic [3:0] stage, input logic step,
                            input logic done, input logic busy);
        checkOutput({tag, ".stage"}, 32'(bus.stage_out), 32'(stage));
        checkOutput({tag, ".step"},  32'(bus.step_one),  32'(step));
        checkOutput({tag, ".done"},  32'(bus.done),      32'(done));
        checkOutput({tag, ".busy"},  32'(bus.busy),      32'(busy));
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd1);
        tick();
    endtask

    initial begin
        logic [3:0] expStage;
        logic       expStep;
        int         lastN;
        testsRun    = 0;
        testsFailed = 0;
        r_n         = 1'b0;
`ifdef SEQ_PAUSE_EN
        bus.pause   = 1'b0;
`endif

        // Reset holds everything low even with START asserted.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll($sformatf("reset%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd3);
        r_n = 1'b1;
        tick();
        checkAll("postreset", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Ascending loop, LEN=3.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd3);
        for (int n = 1; n <= 13; n++) begin
            expStage = 4'(oneHot(((n - 1) / 3) % 4));
            expStep  = ((n - 1) % 3) == 0;
            checkAll($sformatf("loop@%0d", n), expStage, expStep, 1'b0, 1'b1);
            tick();
        end
        goIdle();

        // Descending single pass, LEN=2.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 24'd2);
        for (int n = 1; n <= 8; n++) begin
            expStage = 4'(oneHot(3 - (n - 1) / 2));
            expStep  = ((n - 1) % 2) == 0;
            checkAll($sformatf("pass@%0d", n), expStage, expStep, 1'b0, 1'b1);
            tick();
        end
        checkAll("pass@9", 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkAll("pass@10", 4'b0000, 1'b0, 1'b0, 1'b0);
        goIdle();

        // LEN=0 advances every cycle; STOP and START together at @6.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        tick();
        for (int n = 1; n <= 6; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
            checkAll($sformatf("len0@%0d", n), 4'(oneHot((n - 1) % 4)), 1'b1, 1'b0, 1'b1);
            if (n == 6)
                applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        checkAll("len0@7", 4'b0000, 1'b0, 1'b0, 1'b0);
        goIdle();

        // Retrigger at @12 while in stage 0100, LEN=5.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'd5);
        tick();
        for (int n = 1; n <= 18; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd5);
            if (n <= 12)
                expStage = 4'(oneHot((n - 1) / 5));
            else if (n <= 17)
                expStage = 4'b0001;
            else
                expStage = 4'b0010;
            expStep = (n <= 11) ? (((n - 1) % 5) == 0) : ((n == 13) || (n == 18));
            checkAll($sformatf("retrig@%0d", n), expStage, expStep, 1'b0, 1'b1);
            if (n == 12)
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'd5);
            tick();
        end
        goIdle();

        // Pause window (edges 2..8) stretches stage 0001 when the feature is built in.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd4);
`ifdef SEQ_PAUSE_EN
        lastN = 12;
`else
        lastN = 8;
`endif
        for (int n = 1; n <= lastN; n++) begin
`ifdef SEQ_PAUSE_EN
            expStage = (n <= 11) ? 4'b0001 : 4'b0010;
`else
            expStage = (n <= 4) ? 4'b0001 : 4'b0010;
`endif
            checkAll($sformatf("pause@%0d", n), expStage, (n == 1) || (expStage == 4'b0010 && (n == 5 || n == 12)) ? 1'b1 : 1'b0, 1'b0, 1'b1);
`ifdef SEQ_PAUSE_EN
            bus.pause = (n >= 2) && (n <= 8);
`endif
            tick();
        end
`ifdef SEQ_PAUSE_EN
        bus.pause = 1'b0;
`endif
        goIdle();
        checkAll("final", 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
